// File: rtl/reg16_file.sv
// rtl/reg16_file.sv - 16-bit register file with bus latch, address register and inc/dec unit
// Optional macro REG16_POSTBOOT_INIT_EN: reset to DMG post-boot-ROM register values.
module reg16_file (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [5:0]  i_Read16,
    input  logic [5:0]  i_Write16,
    input  logic        i_Address_Out,
    input  logic [1:0]  i_Increment16,
    input  logic [5:0]  i_Load16,
    input  logic [15:0] i_Data16,
    output logic [15:0] o_Address,
    output logic [15:0] o_Bus16,
    output logic [15:0] o_PC
);

    localparam int NREG = 6;
    localparam int PC_IDX = 5;

    // Index order: BC, DE, HL, SP, WZ, PC
`ifdef REG16_POSTBOOT_INIT_EN
    localparam logic [15:0] RESET_VALUE [NREG] = '{
        16'h0013, 16'h00D8, 16'h014D, 16'hFFFE, 16'h0000, 16'h0100
    };
`else
    localparam logic [15:0] RESET_VALUE [NREG] = '{
        16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000
    };
`endif

    logic [15:0] regs [NREG];
    logic [15:0] bus_mux;
    logic [15:0] idu_result;

    // Later iterations override earlier ones, so the highest set index wins.
    always_comb begin
        bus_mux = o_Bus16;
        for (int i = 0; i < NREG; i++) begin
            if (i_Read16[i]) begin
                bus_mux = regs[i];
            end
        end
    end

    always_comb begin
        case (i_Increment16)
            2'b01:   idu_result = o_Bus16 + 16'd1;
            2'b10:   idu_result = o_Bus16 - 16'd1;
            default: idu_result = o_Bus16;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_Bus16   <= 16'h0000;
            o_Address <= 16'h0000;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= RESET_VALUE[i];
            end
        end else begin
            o_Bus16 <= bus_mux;
            if (i_Address_Out) begin
                o_Address <= bus_mux;
            end
            for (int i = 0; i < NREG; i++) begin
                if (i_Load16[i]) begin
                    regs[i] <= i_Data16;
                end else if (i_Write16[i]) begin
                    regs[i] <= idu_result;
                end
            end
        end
    end

    assign o_PC = regs[PC_IDX];

endmodule
